// File: rtl/iir_fold_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iir_fold_param : biquad IIR, one multiplier folded over 5 taps per sample
// Revision 1.0
// ---------------------------------------------------------------------------
module iir_fold_param #(
  parameter int WIDTH  = 10,
  parameter int COEF_W = 12,
  parameter int FRAC   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  data_in,
  input  logic signed [COEF_W-1:0] b0,
  input  logic signed [COEF_W-1:0] b1,
  input  logic signed [COEF_W-1:0] b2,
  input  logic signed [COEF_W-1:0] a1,
  input  logic signed [COEF_W-1:0] a2,
  input  logic                     bypass,
  output logic signed [WIDTH-1:0]  data_out,
  output logic                     out_valid
);

  localparam int PROD_W = WIDTH + COEF_W;
  localparam int ACC_W  = PROD_W + 3;
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               tap_q, tap_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [WIDTH-1:0]  x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
  logic signed [WIDTH-1:0]  y1_q, y1_d, y2_q, y2_d;
  logic signed [COEF_W-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;
  logic                     byp_q, byp_d;
  logic signed [WIDTH-1:0]  data_out_q, data_out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d;

  logic signed [COEF_W-1:0] mac_coef;
  logic signed [WIDTH-1:0]  mac_samp;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [WIDTH-1:0]  y_new;

  // Tap order: b0*x[n], b1*x[n-1], b2*x[n-2], then the two feedback terms
  always_comb begin
    mac_coef = '0;
    mac_samp = '0;
    case (tap_q)
      3'd0: begin mac_coef = b0_q; mac_samp = x0_q; end
      3'd1: begin mac_coef = b1_q; mac_samp = x1_q; end
      3'd2: begin mac_coef = b2_q; mac_samp = x2_q; end
      3'd3: begin mac_coef = a1_q; mac_samp = y1_q; end
      3'd4: begin mac_coef = a2_q; mac_samp = y2_q; end
      default: begin mac_coef = '0; mac_samp = '0; end
    endcase
  end

  assign prod    = PROD_W'(mac_coef) * PROD_W'(mac_samp);
  assign shifted = acc_q >>> FRAC;

  always_comb begin
    if (byp_q)                y_new = x0_q;
    else if (shifted > Y_MAX) y_new = Y_MAX[WIDTH-1:0];
    else if (shifted < Y_MIN) y_new = Y_MIN[WIDTH-1:0];
    else                      y_new = shifted[WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    byp_d       = byp_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x0_d    = data_in;
          b0_d    = b0;
          b1_d    = b1;
          b2_d    = b2;
          a1_d    = a1;
          a2_d    = a2;
          byp_d   = bypass;
          tap_d   = 3'd0;
          acc_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        if (tap_q < 3'd3) acc_d = acc_q + ACC_W'(prod);
        else              acc_d = acc_q - ACC_W'(prod);
        if (tap_q == 3'd4) begin
          state_d = DONE;
          tap_d   = 3'd0;
        end else begin
          tap_d = tap_q + 3'd1;
        end
      end
      DONE: begin
        data_out_d  = y_new;
        out_valid_d = 1'b1;
        x2_d        = x1_q;
        x1_d        = x0_q;
        y2_d        = y1_q;
        y1_d        = y_new;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      acc_q       <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      byp_q       <= 1'b0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      byp_q       <= byp_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_fold_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_iir_fold_param : directed + random checks against an arithmetic model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_iir_fold_param;
  localparam int WIDTH  = 10;
  localparam int COEF_W = 12;
  localparam int FRAC   = 10;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [WIDTH-1:0]  data_in;
  logic signed [COEF_W-1:0] b0, b1, b2, a1, a2;
  logic                     bypass;
  logic signed [WIDTH-1:0]  data_out;
  logic                     out_valid;

  int checks   = 0;
  int failures = 0;
  int mx1, mx2, my1, my2;

  iir_fold_param #(.WIDTH(WIDTH), .COEF_W(COEF_W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .bypass(bypass), .data_out(data_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_y(input int x, input int c0, input int c1, input int c2,
                               input int d1, input int d2, input bit byp);
    longint acc;
    longint y;
    longint hi;
    longint lo;
    if (byp) return x;
    hi  = (longint'(1) <<< (WIDTH-1)) - 1;
    lo  = -(longint'(1) <<< (WIDTH-1));
    acc = longint'(c0)*x + longint'(c1)*mx1 + longint'(c2)*mx2
        - longint'(d1)*my1 - longint'(d2)*my2;
    y = acc >>> FRAC;
    if (y > hi) y = hi;
    if (y < lo) y = lo;
    return int'(y);
  endfunction

  task automatic ref_push(input int x, input int y);
    mx2 = mx1; mx1 = x;
    my2 = my1; my1 = y;
  endtask

  task automatic ref_clear();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    rst = 1'b1;
    ref_clear();
  endtask

  // One sample: latency, busy window, result, single-cycle pulse and hold
  task automatic send(input int x, input int c0, input int c1, input int c2,
                      input int d1, input int d2, input bit byp, output int y_obs);
    int exp_y;
    exp_y = ref_y(x, c0, c1, c2, d1, d2, byp);
    @(negedge clk);
    check("ready_before_accept", {31'd0, in_ready}, 1);
    data_in  = WIDTH'(x);
    b0 = COEF_W'(c0); b1 = COEF_W'(c1); b2 = COEF_W'(c2);
    a1 = COEF_W'(d1); a2 = COEF_W'(d2);
    bypass   = byp;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = WIDTH'($urandom);
    b0 = COEF_W'($urandom); b1 = COEF_W'($urandom); b2 = COEF_W'($urandom);
    a1 = COEF_W'($urandom); a2 = COEF_W'($urandom);
    bypass   = ~byp;
    for (int k = 0; k < 6; k++) begin
      check("busy_in_ready", {31'd0, in_ready}, 0);
      check("busy_out_valid", {31'd0, out_valid}, 0);
      @(negedge clk);
    end
    check("done_out_valid", {31'd0, out_valid}, 1);
    check("done_data_out", data_out, exp_y);
    check("done_in_ready", {31'd0, in_ready}, 1);
    y_obs = int'(data_out);
    ref_push(x, exp_y);
    @(negedge clk);
    check("pulse_width", {31'd0, out_valid}, 0);
    check("hold_data_out", data_out, exp_y);
  endtask

  initial begin
    int y;
    int acc_cnt;
    int pulse_cnt;
    int ov_seen;
    int e1, e2, e3;
    int pulse_edge[$];
    int vals[$];

    rst = 1'b0; in_valid = 1'b0; data_in = '0; bypass = 1'b0;
    b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    ref_clear();

    // Reset state and impulse with zero history
    do_reset();
    send(100, 1024, 0, 0, 0, 0, 1'b0, y);
    check("impulse", y, 100);

    // First-order recursion
    do_reset();
    send(100, 1024, 0, 0, -512, 0, 1'b0, y); check("recur0", y, 100);
    send(0,   1024, 0, 0, -512, 0, 1'b0, y); check("recur1", y, 50);
    send(0,   1024, 0, 0, -512, 0, 1'b0, y); check("recur2", y, 25);

    // Saturation and saturated feedback
    do_reset();
    send(400,  2047, 0, 0, 0, 0, 1'b0, y);     check("sat_pos", y, 511);
    send(-400, 2047, 0, 0, 0, 0, 1'b0, y);     check("sat_neg", y, -512);
    send(0,    0,    0, 0, -1024, 0, 1'b0, y); check("sat_fb", y, -512);

    // in_valid held high; b0 changes mid-flight
    do_reset();
    acc_cnt = 0; pulse_cnt = 0;
    @(negedge clk);
    data_in = 10'sd50; b0 = 12'sd1024; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    bypass = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 21; c++) begin
      if (in_ready) acc_cnt++;
      @(negedge clk);
      if (c == 1) b0 = '0;
      if (out_valid) begin
        pulse_cnt++;
        pulse_edge.push_back(c);
        vals.push_back(int'(data_out));
      end
    end
    in_valid = 1'b0;
    e1 = ref_y(50, 1024, 0, 0, 0, 0, 1'b0); ref_push(50, e1);
    e2 = ref_y(50, 0, 0, 0, 0, 0, 1'b0);    ref_push(50, e2);
    e3 = ref_y(50, 0, 0, 0, 0, 0, 1'b0);    ref_push(50, e3);
    check("hold_accepts", acc_cnt, 3);
    check("hold_pulses", pulse_cnt, 3);
    if (pulse_cnt == 3) begin
      check("hold_edge0", pulse_edge[0], 6);
      check("hold_edge1", pulse_edge[1], 13);
      check("hold_edge2", pulse_edge[2], 20);
      check("hold_val0_shadow", vals[0], 50);
      check("hold_val1", vals[1], e2);
      check("hold_val2", vals[2], e3);
    end

    // Abort by reset mid-computation, then bypass
    do_reset();
    send(200, 1024, 0, 0, 0, 0, 1'b0, y); check("pre_abort", y, 200);
    @(negedge clk);
    data_in = 10'sd80; b0 = 12'sd1024; bypass = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ref_clear();
    check("abort_out_valid", {31'd0, out_valid}, 0);
    check("abort_in_ready", {31'd0, in_ready}, 1);
    check("abort_data_out", data_out, 0);
    ov_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("abort_no_pulse", ov_seen, 0);
    send(5, 0, 1024, 0, 0, 0, 1'b0, y); check("abort_hist_cleared", y, 0);
    send(-37, 1500, -700, 300, 900, -400, 1'b1, y); check("bypass", y, -37);
    send(0, 0, 1024, 0, 0, 0, 1'b0, y); check("bypass_hist", y, -37);

    // Random samples against the model
    for (int n = 0; n < 40; n++) begin
      int rx, r0, r1, r2, r3, r4;
      bit rb;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rx = int'($urandom_range(0, 1023)) - 512;
      r0 = int'($urandom_range(0, 4095)) - 2048;
      r1 = int'($urandom_range(0, 4095)) - 2048;
      r2 = int'($urandom_range(0, 4095)) - 2048;
      r3 = int'($urandom_range(0, 4095)) - 2048;
      r4 = int'($urandom_range(0, 4095)) - 2048;
      rb = ($urandom_range(0, 7) == 0);
      send(rx, r0, r1, r2, r3, r4, rb, y);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/iir_fold_param.md
IIR_FOLD_PARAM -- requirements
Module: iir_fold_param

Interface
REQ-001 Parameter WIDTH, default 10: signed sample width of data_in and data_out.
REQ-002 Parameter COEF_W, default 12: signed coefficient width.
REQ-003 Parameter FRAC, default 10: coefficient fractional bits; 1.0 = 2^FRAC.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 in_valid  in  1  data_in holds a new sample.
REQ-007 in_ready  out  1  block can accept a sample this cycle.
REQ-008 data_in  in  WIDTH  signed input sample x[n].
REQ-009 b0, b1, b2, a1, a2  in  COEF_W each  signed coefficients.
REQ-010 bypass  in  1  mode select; 1 = pass x[n] through unfiltered.
REQ-011 data_out  out  WIDTH  signed output sample y[n], registered.
REQ-012 out_valid  out  1  one-cycle pulse; data_out holds a new result.

Function
REQ-013 The block SHALL compute y[n] = sat((b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]) >>> FRAC).
- >>> is arithmetic shift right (floor).
- sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-014 The block SHALL use exactly one multiplier, time-shared over 5 MAC cycles per sample (folding factor 5).
REQ-015 The accumulator SHALL be WIDTH+COEF_W+3 bits signed; no internal overflow is permitted before saturation.
REQ-016 The FSM SHALL have states IDLE, MAC and DONE.
- IDLE -> MAC on in_valid & in_ready.
- MAC holds tap index 0..4 and moves to DONE after tap 4.
- DONE -> IDLE unconditionally.
REQ-017 in_ready SHALL be 1 only in IDLE; a sample is accepted only on a clock edge where in_valid=1 and in_ready=1.
REQ-018 On accept, the block SHALL capture data_in, b0..a2 and bypass into shadow registers; port changes during MAC/DONE SHALL NOT affect the sample in flight.
REQ-019 On the DONE edge, the block SHALL perform all of the following:
- load data_out with the result;
- pulse out_valid;
- shift history: x[n-2]<=x[n-1], x[n-1]<=x[n], y[n-2]<=y[n-1], y[n-1]<=saturated y[n].
REQ-020 Latency SHALL be 7 edges from accept (edge 0) to the DONE edge (edge 6); throughput is 1 sample per 7 cycles.
REQ-021 data_out SHALL hold its value between results; out_valid SHALL be 1 for exactly one cycle per accepted sample.
REQ-022 With bypass latched 1, data_out SHALL equal x[n] at the same latency, and history SHALL still update with y[n]=x[n].
REQ-023 Fed-back history SHALL be the saturated output, never the unsaturated accumulator.
REQ-024 in_valid low in IDLE SHALL leave all state unchanged.

Reset
REQ-025 When rst=0 at a clock edge, the block SHALL apply all of the following:
- FSM to IDLE, tap index 0, accumulator 0;
- all x/y history 0, shadow registers 0;
- data_out=0, out_valid=0, in_ready=1 from the following cycle.
REQ-026 Reset asserted during MAC or DONE SHALL abort the sample: no out_valid pulse and no history update for it.
REQ-027 rst SHALL have no asynchronous effect; outputs change only at clock edges.

Verification
REQ-028 Reset: rst=0 for 2 cycles -> data_out=0, out_valid=0, in_ready=1; the first sample after release uses zero history.
REQ-029 Impulse: b0=1024, others 0, data_in=100 -> data_out=100 with out_valid pulsed at edge 6 after accept; in_ready=0 for edges 1-6.
REQ-030 Recursion: b0=1024, a1=-512, others 0, inputs 100,0,0 -> outputs 100,50,25.
REQ-031 Saturation: b0=2047, data_in=400 -> data_out=511; data_in=-400 -> data_out=-512; next sample with b0=0 and a1=-1024 -> -512 (saturated feedback).
REQ-032 Hold/shadow: in_valid held high continuously and b0 changed 1024->0 at edge 2 of a computation -> the in-flight result uses 1024; exactly one accept per 7 cycles.
REQ-033 Abort and bypass:
- rst=0 at edge 3 of a computation -> no out_valid, history cleared;
- then bypass=1, data_in=-37 -> data_out=-37 at edge 6.
